// File: rtl/vector_fetch_sequencer.sv
// rtl/vector_fetch_sequencer.sv - AVG display-list walker: fetch, decode, JSRL/RTSL stack, command handshake.
// Optional stack fault guard enabled by defining VFS_STACK_GUARD_EN.
module vector_fetch_sequencer #(
  parameter int ADDR_W      = 13,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk_12,
  input  logic              reset,
  input  logic              evg_go,
  input  logic              evg_res,
  output logic              halted,
  output logic              stack_err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_kind,
  output logic [12:0]       cmd_dx,
  output logic [12:0]       cmd_dy,
  output logic [2:0]        cmd_z,
  output logic [10:0]       cmd_param
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
`ifdef VFS_STACK_GUARD_EN
  localparam int SP_W = IDX_W + 1;
`else
  localparam int SP_W = IDX_W;
`endif

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DEC0, S_DEC1, S_EMIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stack_err_q, stack_err_d;
  logic [1:0]        kind_q, kind_d;
  logic [12:0]       dx_q, dx_d, dy_q, dy_d;
  logic [2:0]        z_q, z_d;
  logic [10:0]       param_q, param_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              stack_we;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] pc_inc, jump_tgt;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic [12:0]       svec_dx, svec_dy;
  logic              stack_full, stack_empty;

  assign opcode   = mem_data[15:13];
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign jump_tgt = ADDR_W'(mem_data[12:0]);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
  // Short-vector fields are 5-bit signed, scaled by two.
  assign svec_dy  = {{7{mem_data[12]}}, mem_data[12:8], 1'b0};
  assign svec_dx  = {{7{mem_data[4]}}, mem_data[4:0], 1'b0};

`ifdef VFS_STACK_GUARD_EN
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
`else
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b0;
`endif

  assign halted    = (state_q == S_IDLE);
  assign cmd_valid = (state_q == S_EMIT);
  assign stack_err = stack_err_q;
  assign cmd_kind  = kind_q;
  assign cmd_dx    = dx_q;
  assign cmd_dy    = dy_q;
  assign cmd_z     = z_q;
  assign cmd_param = param_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    kind_d      = kind_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    z_d         = z_q;
    param_d     = param_q;
    stack_we    = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    case (state_q)
      S_IDLE: begin
        if (evg_go) begin
          state_d = S_FETCH;
          pc_d    = '0;
          sp_d    = '0;
        end
      end
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        state_d  = S_DEC0;
      end
      S_DEC0: begin
        case (opcode)
          3'b000: begin
            mem_rd   = 1'b1;
            mem_addr = pc_inc;
            pc_d     = pc_inc;
            kind_d   = 2'd0;
            dy_d     = mem_data[12:0];
            param_d  = '0;
            state_d  = S_DEC1;
          end
          3'b001: state_d = S_IDLE;
          3'b010: begin
            kind_d  = 2'd0;
            dy_d    = svec_dy;
            dx_d    = svec_dx;
            z_d     = mem_data[7:5];
            param_d = '0;
            pc_d    = pc_inc;
            state_d = S_EMIT;
          end
          3'b011: begin
            kind_d  = mem_data[12] ? 2'd2 : 2'd1;
            param_d = mem_data[12] ? mem_data[10:0] : {3'b000, mem_data[7:0]};
            dx_d    = '0;
            dy_d    = '0;
            z_d     = '0;
            pc_d    = pc_inc;
            state_d = S_EMIT;
          end
          3'b100: begin
            kind_d  = 2'd3;
            param_d = '0;
            dx_d    = '0;
            dy_d    = '0;
            z_d     = '0;
            pc_d    = pc_inc;
            state_d = S_EMIT;
          end
          3'b101: begin
            if (stack_full) begin
              stack_err_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              stack_we = 1'b1;
              sp_d     = sp_q + SP_W'(1);
              pc_d     = jump_tgt;
              state_d  = S_FETCH;
            end
          end
          3'b110: begin
            if (stack_empty) begin
              stack_err_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              sp_d    = sp_q - SP_W'(1);
              pc_d    = stack_q[pop_idx];
              state_d = S_FETCH;
            end
          end
          default: begin
            pc_d    = jump_tgt;
            state_d = S_FETCH;
          end
        endcase
      end
      S_DEC1: begin
        dx_d    = mem_data[12:0];
        z_d     = mem_data[15:13];
        pc_d    = pc_inc;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (cmd_ready) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort outranks everything, including a simultaneous start.
    if (evg_res) begin
      state_d     = S_IDLE;
      pc_d        = '0;
      sp_d        = '0;
      stack_err_d = 1'b0;
      stack_we    = 1'b0;
    end
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      kind_q      <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      z_q         <= '0;
      param_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
      kind_q      <= kind_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      z_q         <= z_d;
      param_q     <= param_d;
    end
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (stack_we) begin
      stack_q[push_idx] <= pc_inc;
    end
  end
endmodule
